// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// mult/div occupancy sequencer.
package pipe_hazard_ctrl_pkg;

  typedef logic [0:0] md_state_t;

  localparam md_state_t IDLE = 1'b0;
  localparam md_state_t BUSY = 1'b1;

  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 32;
  localparam int CNT_W       = 5;

  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

  // Counter preload: the BUSY phase lasts preload+1 cycles, ending on cnt==0.
  function automatic logic [CNT_W-1:0] md_preload(input logic is_div);
    return is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Mult/div occupancy sequencer: tracks how long the multi-cycle unit stays busy
// after an issue and flags its final busy cycle.
module md_seq
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic md_go,
  input  logic id_md_div,
  output logic md_busy,
  output logic md_done
);

  md_state_t        r_state;
  md_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_done;
  logic             w_done_next;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_state == IDLE) begin
      if (md_go) begin
        w_state_next = BUSY;
        w_cnt_next   = md_preload(id_md_div);
      end
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end else begin
      w_state_next = IDLE;
    end
    // Done is registered by looking one state ahead.
    w_done_next = (w_state_next == BUSY) && (w_cnt_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  assign md_busy = (r_state == BUSY);
  assign md_done = r_done;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, taken-branch
// flush, and mult/div issue into the occupancy sequencer.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_ra,
  input  logic [4:0] id_rb,
  input  logic       id_useA,
  input  logic       id_useB,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic       id_hilo_rd,
  input  logic [4:0] ex_rw,
  input  logic       ex_regWr,
  input  logic [1:0] ex_memtoreg,
  input  logic       ex_taken,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       BranchBubble,
  output logic       md_go,
  output logic       md_busy,
  output logic       md_done
);

  logic w_load_use;
  logic w_md_hazard;

  assign w_load_use = (ex_memtoreg == MEMTOREG_LOAD) && ex_regWr && (ex_rw != 5'd0) &&
                      ((id_useA && (id_ra == ex_rw)) || (id_useB && (id_rb == ex_rw)));

  assign w_md_hazard = md_busy && (id_hilo_rd || id_md_start);

  // A taken branch outranks any stall: the ID instruction is on the wrong path.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    BranchBubble = 1'b0;
    md_go        = 1'b0;
    if (rst) begin
      BranchBubble = 1'b1;
    end else if (ex_taken) begin
      ifid_flush   = 1'b1;
      BranchBubble = 1'b1;
    end else if (w_load_use || w_md_hazard) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      BranchBubble = 1'b1;
    end else begin
      md_go = id_md_start;
    end
  end

  md_seq u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .md_go     (md_go),
    .id_md_div (id_md_div),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed output
// vectors, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic bubble;
    logic go;
    logic busy;
    logic done;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [4:0] id_ra, id_rb;
  logic       id_useA, id_useB;
  logic       id_md_start, id_md_div, id_hilo_rd;
  logic [4:0] ex_rw;
  logic       ex_regWr;
  logic [1:0] ex_memtoreg;
  logic       ex_taken;
  logic       pc_stall, ifid_stall, ifid_flush, BranchBubble;
  logic       md_go, md_busy, md_done;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_ra        (id_ra),
    .id_rb        (id_rb),
    .id_useA      (id_useA),
    .id_useB      (id_useB),
    .id_md_start  (id_md_start),
    .id_md_div    (id_md_div),
    .id_hilo_rd   (id_hilo_rd),
    .ex_rw        (ex_rw),
    .ex_regWr     (ex_regWr),
    .ex_memtoreg  (ex_memtoreg),
    .ex_taken     (ex_taken),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .BranchBubble (BranchBubble),
    .md_go        (md_go),
    .md_busy      (md_busy),
    .md_done      (md_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_in();
    id_ra = 5'd0; id_rb = 5'd0; id_useA = 1'b0; id_useB = 1'b0;
    id_md_start = 1'b0; id_md_div = 1'b0; id_hilo_rd = 1'b0;
    ex_rw = 5'd0; ex_regWr = 1'b0; ex_memtoreg = 2'b00; ex_taken = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rw);
    ex_memtoreg = 2'b01; ex_regWr = 1'b1; ex_rw = rw;
  endtask

  // Inputs are already applied; queue the expectation for this cycle and advance.
  task automatic cyc(input string name, input exp_t e);
    sb_t s;
    s.name = name;
    s.e    = e;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample mid-cycle, away from both the edge and the input update.
  initial begin
    sb_t  s;
    exp_t act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        s   = sb_q.pop_front();
        act = {pc_stall, ifid_stall, ifid_flush, BranchBubble, md_go, md_busy, md_done};
        checks++;
        if (act !== s.e) begin
          errors++;
          $display("FAIL %s: got {stall,ifstall,flush,bubble,go,busy,done}=%b required %b",
                   s.name, act, s.e);
        end else begin
          $display("ok   %s: outputs=%b", s.name, act);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    #1;

    // Reset state.
    cyc("reset0", 7'b0001000);
    cyc("reset1", 7'b0001000);
    rst = 1'b0;
    cyc("idle", 7'b0000000);

    // Load-use hazards.
    set_load(5'd5); id_ra = 5'd5; id_useA = 1'b1;
    cyc("lu_a", 7'b1101000);
    ex_rw = 5'd0; id_ra = 5'd0;
    cyc("lu_r0", 7'b0000000);
    clear_in(); set_load(5'd7); id_rb = 5'd7; id_useB = 1'b1;
    cyc("lu_b", 7'b1101000);
    id_useB = 1'b0;
    cyc("lu_b_unused", 7'b0000000);
    id_useB = 1'b1; ex_memtoreg = 2'b00;
    cyc("lu_not_load", 7'b0000000);
    ex_memtoreg = 2'b01; ex_regWr = 1'b0;
    cyc("lu_no_wr", 7'b0000000);

    // Branch priority over load-use.
    clear_in(); set_load(5'd5); id_ra = 5'd5; id_useA = 1'b1; ex_taken = 1'b1;
    cyc("prio_taken", 7'b0011000);

    // Wrong-path mult/div is not issued.
    clear_in(); id_md_start = 1'b1; id_md_div = 1'b1; ex_taken = 1'b1;
    cyc("wrongpath", 7'b0011000);
    clear_in();
    cyc("wrongpath_idle", 7'b0000000);

    // Mult: busy N+1..N+4, done at N+4, taken mid-flight does not abort.
    id_md_start = 1'b1;
    cyc("mult_go", 7'b0000100);
    clear_in(); id_hilo_rd = 1'b1;
    cyc("mult_b1", 7'b1101010);
    ex_taken = 1'b1;
    cyc("mult_b2_taken", 7'b0011010);
    ex_taken = 1'b0;
    cyc("mult_b3", 7'b1101010);
    cyc("mult_b4_done", 7'b1101011);
    cyc("mult_release", 7'b0000000);
    clear_in();

    // Back-to-back divs.
    id_md_start = 1'b1; id_md_div = 1'b1;
    cyc("div1_go", 7'b0000100);
    for (int k = 1; k <= 31; k++) cyc($sformatf("div1_stall%0d", k), 7'b1101010);
    cyc("div1_stall32_done", 7'b1101011);
    cyc("div2_go", 7'b0000100);
    clear_in();
    for (int k = 34; k <= 64; k++) cyc($sformatf("div2_busy%0d", k), 7'b0000010);
    cyc("div2_done65", 7'b0000011);
    cyc("div2_idle", 7'b0000000);

    // Reset mid-div: busy drops before the next clock edge.
    id_md_start = 1'b1; id_md_div = 1'b1;
    cyc("div3_go", 7'b0000100);
    clear_in();
    for (int k = 1; k <= 9; k++) cyc($sformatf("div3_busy%0d", k), 7'b0000010);
    rst = 1'b1;
    cyc("div3_async_rst", 7'b0001000);
    cyc("div3_rst_hold", 7'b0001000);
    rst = 1'b0; id_md_start = 1'b1;
    cyc("post_rst_go", 7'b0000100);
    clear_in();
    cyc("post_rst_b1", 7'b0000010);
    cyc("post_rst_b2", 7'b0000010);
    cyc("post_rst_b3", 7'b0000010);
    cyc("post_rst_b4_done", 7'b0000011);
    cyc("post_rst_idle", 7'b0000000);

    for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  pipeline clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- id_ra, id_rb  in  5 each  source registers of the instruction in ID
- id_useA, id_useB  in  1 each  ID instruction reads id_ra / id_rb
- id_md_start  in  1  ID holds a mult/div instruction
- id_md_div  in  1  with id_md_start: 1=div, 0=mult
- id_hilo_rd  in  1  ID holds mfhi/mflo
- ex_rw  in  5  destination register of the instruction in EX
- ex_regWr  in  1  EX instruction writes the register file
- ex_memtoreg  in  2  EX writeback select; 2'b01 = load
- ex_taken  in  1  branch/jump resolved taken in EX
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  clear IF/ID register
- BranchBubble  out  1  insert a bubble into the ID/EX register
- md_go  out  1  one-cycle pulse: mult/div issued this cycle
- md_busy  out  1  registered; mult/div unit occupied
- md_done  out  1  registered; one-cycle pulse in the last busy cycle

Function
REQ-002 load_use SHALL be 1 iff ex_memtoreg==2'b01, ex_regWr==1, ex_rw!=0, and ((id_useA and id_ra==ex_rw) or (id_useB and id_rb==ex_rw)).
REQ-003 md_hazard SHALL be 1 iff md_busy==1 and (id_hilo_rd or id_md_start).
REQ-004 ex_taken SHALL have priority: ifid_flush=1, BranchBubble=1, pc_stall=0, ifid_stall=0, md_go=0.
REQ-005 Otherwise, if load_use or md_hazard: pc_stall=ifid_stall=BranchBubble=1, ifid_flush=0, md_go=0.
REQ-006 Otherwise, md_go SHALL equal id_md_start, and pc_stall, ifid_stall, ifid_flush and BranchBubble SHALL be 0.
REQ-007 All outputs in REQ-002..006 SHALL be combinational, in the same cycle as their inputs.
REQ-008 The FSM SHALL have states IDLE and BUSY, with a 5-bit down-counter cnt.
REQ-009 In IDLE with md_go=1, the next state SHALL be BUSY, with cnt=3 for mult and cnt=31 for div.
REQ-010 In BUSY with cnt!=0, cnt SHALL decrement by 1; in BUSY with cnt==0, the next state SHALL be IDLE.
REQ-011 md_busy SHALL be 1 exactly when the state is BUSY; a mult issued in cycle N SHALL give md_busy=1 in cycles N+1..N+4, a div in cycles N+1..N+32.
REQ-012 md_done SHALL be 1 exactly in the cycle where state==BUSY and cnt==0.
REQ-013 A new id_md_start in the md_done cycle SHALL still stall (md_hazard); it SHALL issue in the next cycle, with no idle gap beyond that cycle.
REQ-014 ex_taken during BUSY SHALL NOT abort the in-flight operation, because the issuing instruction has already left ID.
REQ-015 The counter SHALL never wrap: decrement SHALL be blocked at cnt==0.

Reset
REQ-016 While rst=1: state=IDLE, cnt=0, md_busy=0, md_done=0, pc_stall=ifid_stall=ifid_flush=md_go=0, and BranchBubble=1 so that ID/EX is cleared.
REQ-017 Reset asserted mid-operation SHALL abandon the operation immediately, asynchronously to clk.
REQ-018 In the first cycle after rst falls, the block SHALL be able to issue.

Structure
REQ-019 A shared package SHALL hold: the state type {IDLE, BUSY}; MULT_CYCLES=4; DIV_CYCLES=32; MEMTOREG_LOAD=2'b01.
REQ-020 The FSM and counter SHALL be a single sub-module md_seq (inputs: md_go, id_md_div; outputs: md_busy, md_done); hazard and priority logic SHALL stay in the top level.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load-use: ex_memtoreg=01, ex_regWr=1, ex_rw=5, id_ra=5, id_useA=1 -> pc_stall=ifid_stall=BranchBubble=1; the same case with ex_rw=0 -> all 0.
- Priority: load_use and ex_taken in the same cycle -> ifid_flush=1, BranchBubble=1, pc_stall=0.
- Mult: issue in cycle N -> md_go=1 in N; md_busy=1 in N+1..N+4; md_done=1 only in N+4; id_hilo_rd stalls in N+1..N+4 and is released in N+5.
- Div back-to-back: div issued in N, second div in ID -> stalled in N+1..N+32, md_go=1 in N+33, md_busy=1 in N+34..N+65.
- Reset during div: rst asserted at N+10 -> md_busy=0 asynchronously; after release, an issue succeeds in the first cycle.
- Wrong path: id_md_start with ex_taken=1 -> md_go=0, state remains IDLE.
